mem_arbiter_rr: RTL and testbench

- Parametrised N-master to 1-slave memory-port arbiter using the CPU-interface handshake (transaction_begin/transaction_end).
- Replaces the static select-driven 2:1 mux with round-robin arbitration, registered and held slave-side signals, per-master response routing, and a response timeout.
- Sits between CPU cores or DMA masters and a shared memory controller, such as the HyperRAM or SRAM front-end.

---
 rtl/mem_arbiter_rr.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr
// Brief    : Round-robin N-master to 1-slave memory-port arbiter with held
//            slave-side registers, per-master response routing and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] address_m,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] data_out_m,
    input  logic [NUM_MASTERS-1:0]            write_enable_m,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0] write_mask_m,
    input  logic [NUM_MASTERS-1:0]            transaction_begin_m,
    output logic [DATA_WIDTH-1:0]             data_in_m,
    output logic [NUM_MASTERS-1:0]            transaction_end_m,
    output logic [NUM_MASTERS-1:0]            error_m,
    output logic [ADDR_WIDTH-1:0]             address_y,
    output logic [DATA_WIDTH-1:0]             data_out_y,
    output logic                              write_enable_y,
    output logic [MASK_WIDTH-1:0]             write_mask_y,
    output logic                              transaction_begin_y,
    input  logic [DATA_WIDTH-1:0]             data_in_y,
    input  logic                              transaction_end_y,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant,
    output logic                              busy
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] c_TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit            c_TO_EN   = (TIMEOUT_CYCLES > 0);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]             r_state;
    logic [GW-1:0]          r_last;
    logic [GW-1:0]          r_grant;
    logic [CW-1:0]          r_cnt;
    logic [DATA_WIDTH-1:0]  r_data_in_m;
    logic [NUM_MASTERS-1:0] r_end_m;
    logic [NUM_MASTERS-1:0] r_error_m;
    logic [ADDR_WIDTH-1:0]  r_addr_y;
    logic [DATA_WIDTH-1:0]  r_data_y;
    logic                   r_we_y;
    logic [MASK_WIDTH-1:0]  r_mask_y;
    logic                   r_begin_y;

    logic [GW-1:0]          w_pick;
    logic                   w_any;
    logic [GW:0]            w_sum;
    logic                   w_timeout;

    // Scan last+1, last+2, ... with an explicit wrap so non-power-of-two
    // master counts stay in range.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_sum = {1'b0, r_last} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NUM_MASTERS)) begin
                w_sum = w_sum - (GW+1)'(NUM_MASTERS);
            end
            if (!w_any && transaction_begin_m[w_sum[GW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[GW-1:0];
            end
        end
    end

    assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_last      <= GW'(NUM_MASTERS - 1);
            r_grant     <= '0;
            r_cnt       <= '0;
            r_data_in_m <= '0;
            r_end_m     <= '0;
            r_error_m   <= '0;
            r_addr_y    <= '0;
            r_data_y    <= '0;
            r_we_y      <= 1'b0;
            r_mask_y    <= '0;
            r_begin_y   <= 1'b0;
        end else begin
            r_begin_y <= 1'b0;
            r_end_m   <= '0;
            r_error_m <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_pick;
                        r_addr_y  <= address_m[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                        r_data_y  <= data_out_m[w_pick*DATA_WIDTH +: DATA_WIDTH];
                        r_we_y    <= write_enable_m[w_pick];
                        r_mask_y  <= write_mask_m[w_pick*MASK_WIDTH +: MASK_WIDTH];
                        r_begin_y <= 1'b1;
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (transaction_end_y) begin
                        r_data_in_m      <= data_in_y;
                        r_end_m[r_grant] <= 1'b1;
                        r_state          <= c_RESP;
                    end else begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (transaction_end_y) begin
                        r_data_in_m      <= data_in_y;
                        r_end_m[r_grant] <= 1'b1;
                        r_state          <= c_RESP;
                    end else if (w_timeout) begin
                        r_data_in_m        <= '1;
                        r_end_m[r_grant]   <= 1'b1;
                        r_error_m[r_grant] <= 1'b1;
                        r_state            <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_last  <= r_grant;
                    r_cnt   <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign data_in_m           = r_data_in_m;
    assign transaction_end_m   = r_end_m;
    assign error_m             = r_error_m;
    assign address_y           = r_addr_y;
    assign data_out_y          = r_data_y;
    assign write_enable_y      = r_we_y;
    assign write_mask_y        = r_mask_y;
    assign transaction_begin_y = r_begin_y;
    assign grant               = r_grant;
    assign busy                = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// Testbench for mem_arbiter_rr: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_mem_arbiter_rr;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 4;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N*AW-1:0]   address_m;
    logic [N*DW-1:0]   data_out_m;
    logic [N-1:0]      write_enable_m;
    logic [N*MW-1:0]   write_mask_m;
    logic [N-1:0]      transaction_begin_m;
    logic [DW-1:0]     data_in_m;
    logic [N-1:0]      transaction_end_m;
    logic [N-1:0]      error_m;
    logic [AW-1:0]     address_y;
    logic [DW-1:0]     data_out_y;
    logic              write_enable_y;
    logic [MW-1:0]     write_mask_y;
    logic              transaction_begin_y;
    logic [DW-1:0]     data_in_y;
    logic              transaction_end_y;
    logic [GW-1:0]     grant;
    logic              busy;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MASK_WIDTH(MW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .address_m(address_m), .data_out_m(data_out_m),
        .write_enable_m(write_enable_m), .write_mask_m(write_mask_m),
        .transaction_begin_m(transaction_begin_m),
        .data_in_m(data_in_m), .transaction_end_m(transaction_end_m),
        .error_m(error_m), .address_y(address_y), .data_out_y(data_out_y),
        .write_enable_y(write_enable_y), .write_mask_y(write_mask_y),
        .transaction_begin_y(transaction_begin_y), .data_in_y(data_in_y),
        .transaction_end_y(transaction_end_y), .grant(grant), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;

    // Reference model: a timeline of the current transaction in cycle numbers
    int          m_last, m_g, m_gn, m_iss, m_e, m_resp, m_next_idle;
    bit          m_err;
    logic [DW-1:0] m_data, m_rdata, m_wdata, m_dn;
    logic [AW-1:0] m_addr, m_an;
    logic          m_we, m_wn;
    logic [MW-1:0] m_mask, m_kn;

    // Master-side behaviour
    bit            pending [N];
    int            free_from [N];
    int            done_at [N];
    bit            want [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] wd [N];
    logic          we_v [N];
    logic [MW-1:0] mk [N];
    logic          beg_v [N];
    bit            rnd_mode, fixed_addr, fixed_rdata;
    int            force_d;

    // Observations taken from the DUT
    int            olog [$];
    int            n_end, n_err, n_begin, t_begin, t_end, t_raise;
    logic [N-1:0]  last_end, last_err;
    logic [DW-1:0] last_data;
    logic [AW-1:0] obs_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            address_m[i*AW +: AW]  = a[i];
            data_out_m[i*DW +: DW] = wd[i];
            write_enable_m[i]      = we_v[i];
            write_mask_m[i*MW +: MW] = mk[i];
            transaction_begin_m[i] = beg_v[i];
        end
    endtask

    task automatic randomize_payload(input int i);
        a[i]    = (fixed_addr) ? 32'h100 : $urandom;
        wd[i]   = $urandom;
        we_v[i] = 1'($urandom_range(0, 1));
        mk[i]   = 4'($urandom_range(0, 15));
    endtask

    task automatic model_reset();
        m_last = N - 1; m_g = 0; m_gn = 0;
        m_iss = -10; m_e = -10; m_resp = -10; m_next_idle = 0; m_err = 1'b0;
        m_data = '0; m_rdata = '0; m_wdata = '0; m_dn = '0;
        m_addr = '0; m_an = '0; m_we = 1'b0; m_wn = 1'b0; m_mask = '0; m_kn = '0;
        rnd_mode = 1'b0; fixed_addr = 1'b0; fixed_rdata = 1'b0; force_d = -1;
        for (int i = 0; i < N; i++) begin
            pending[i] = 1'b0; free_from[i] = 0; done_at[i] = 1 << 30;
            want[i] = 1'b0; beg_v[i] = 1'b0;
            a[i] = '0; wd[i] = '0; we_v[i] = 1'b0; mk[i] = '0;
        end
        olog.delete();
        n_end = 0; n_err = 0; n_begin = 0; t_begin = 0; t_end = 0; t_raise = 0;
        last_end = '0; last_err = '0; last_data = '0; obs_addr = '0;
        pack();
        transaction_end_y = 1'b0;
        data_in_y = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data_in_m"}, 64'(data_in_m), 64'(0));
        chk({tag, "_end_m"}, 64'(transaction_end_m), 64'(0));
        chk({tag, "_error_m"}, 64'(error_m), 64'(0));
        chk({tag, "_address_y"}, 64'(address_y), 64'(0));
        chk({tag, "_data_out_y"}, 64'(data_out_y), 64'(0));
        chk({tag, "_we_y"}, 64'(write_enable_y), 64'(0));
        chk({tag, "_mask_y"}, 64'(write_mask_y), 64'(0));
        chk({tag, "_begin_y"}, 64'(transaction_begin_y), 64'(0));
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // One clock cycle: compare DUT against the model, then drive the next inputs.
    task automatic cycle();
        logic [N-1:0]  oh;
        bit            resp_now;
        logic [DW-1:0] rdata_now;
        int            g, d, idx;
        @(posedge clk); #1; t++;
        if (t == m_iss) begin
            m_g = m_gn; m_addr = m_an; m_wdata = m_dn; m_we = m_wn; m_mask = m_kn;
        end
        if (t == m_e) m_data = m_err ? '1 : m_rdata;
        oh = '0;
        oh[m_g] = 1'b1;
        chk("busy", 64'(busy), 64'(t >= m_iss && t <= m_e));
        chk("begin_y", 64'(transaction_begin_y), 64'(t == m_iss));
        chk("grant", 64'(grant), 64'(m_g));
        chk("end_m", 64'(transaction_end_m), 64'((t == m_e) ? oh : '0));
        chk("error_m", 64'(error_m), 64'((t == m_e && m_err) ? oh : '0));
        chk("data_in_m", 64'(data_in_m), 64'(m_data));
        chk("address_y", 64'(address_y), 64'(m_addr));
        chk("data_out_y", 64'(data_out_y), 64'(m_wdata));
        chk("we_y", 64'(write_enable_y), 64'(m_we));
        chk("mask_y", 64'(write_mask_y), 64'(m_mask));

        if (transaction_begin_y === 1'b1) begin
            olog.push_back(int'(grant)); t_begin = t; obs_addr = address_y; n_begin++;
        end
        if (transaction_end_m !== '0) begin
            n_end++; last_end = transaction_end_m; last_data = data_in_m; t_end = t;
        end
        if (error_m !== '0) begin
            n_err++; last_err = error_m;
        end

        // Masters hold until they see their end pulse, then drop for a cycle
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                if (t == done_at[i] + 1) begin
                    pending[i] = 1'b0; beg_v[i] = 1'b0; free_from[i] = t + 1;
                    randomize_payload(i);
                end
            end else if (t >= free_from[i] &&
                         (rnd_mode ? ($urandom_range(0, 2) == 0) : want[i])) begin
                pending[i] = 1'b1; beg_v[i] = 1'b1; done_at[i] = 1 << 30; t_raise = t;
                randomize_payload(i);
            end else begin
                beg_v[i] = 1'b0;
                randomize_payload(i);
            end
        end
        pack();

        resp_now  = (t == m_resp);
        rdata_now = m_rdata;
        if (t >= m_next_idle) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && pending[idx]) g = idx;
            end
            if (g >= 0) begin
                d = (force_d >= 0) ? force_d : int'($urandom_range(0, 6));
                m_last = g; m_gn = g;
                m_an = a[g]; m_dn = wd[g]; m_wn = we_v[g]; m_kn = mk[g];
                m_err = (d > TO);
                m_iss = t + 1;
                m_resp = t + 1 + d;
                m_e = m_err ? t + 2 + TO : t + 2 + d;
                m_next_idle = m_e + 1;
                done_at[g] = m_e;
                m_rdata = fixed_rdata ? 32'hDEADBEEF : $urandom;
            end
        end
        transaction_end_y = resp_now;
        data_in_y = resp_now ? rdata_now : $urandom;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk_zero("rst");
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Single read from master 2
        want[2] = 1'b1; fixed_addr = 1'b1; fixed_rdata = 1'b1; force_d = 3;
        for (int c = 0; c < 20 && n_end == 0; c++) cycle();
        chk("single_begin_latency", 64'(t_begin - t_raise), 64'(1));
        chk("single_address_y", 64'(obs_addr), 64'(32'h100));
        chk("single_end_m", 64'(last_end), 64'(4'b0100));
        chk("single_data_in_m", 64'(last_data), 64'(32'hDEADBEEF));

        // Contention between masters 0 and 1
        do_reset();
        want[0] = 1'b1; want[1] = 1'b1; force_d = 1;
        for (int c = 0; c < 100 && olog.size() < 4; c++) cycle();
        chk("contention_count", 64'(olog.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk("contention_grant", 64'(olog[k]), 64'(k % 2));

        // Fairness with all masters requesting
        do_reset();
        for (int i = 0; i < N; i++) want[i] = 1'b1;
        force_d = 2;
        for (int c = 0; c < 200 && olog.size() < 8; c++) cycle();
        chk("fair_count", 64'(olog.size()), 64'(8));
        for (int k = 0; k < 8; k++) chk("fair_grant", 64'(olog[k]), 64'(k % 4));

        // Timeout with a late stray response landing in IDLE
        do_reset();
        want[0] = 1'b1; force_d = 6;
        for (int c = 0; c < 30 && n_err == 0; c++) cycle();
        want[0] = 1'b0;
        repeat (4) cycle();
        chk("timeout_err_count", 64'(n_err), 64'(1));
        chk("timeout_error_m", 64'(last_err), 64'(4'b0001));
        chk("timeout_data", 64'(last_data), 64'(32'hFFFFFFFF));
        chk("timeout_end_count", 64'(n_end), 64'(1));

        // Zero-wait slave
        do_reset();
        want[1] = 1'b1; force_d = 0;
        for (int c = 0; c < 20 && n_end == 0; c++) cycle();
        want[1] = 1'b0;
        repeat (2) cycle();
        chk("zerowait_latency", 64'(t_end - t_raise), 64'(2));
        chk("zerowait_begin_cycles", 64'(n_begin), 64'(1));

        // Asynchronous reset in the middle of WAIT
        do_reset();
        want[3] = 1'b1; force_d = 6;
        repeat (3) cycle();
        chk("pre_reset_busy", 64'(busy), 64'(1));
        #3 reset = 1'b1;
        #1 chk_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) want[i] = 1'b1;
        for (int c = 0; c < 10 && olog.size() < 1; c++) cycle();
        chk("post_reset_grant", 64'(olog[0]), 64'(0));

        // Randomized traffic
        do_reset();
        rnd_mode = 1'b1;
        repeat (500) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
